// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction-memory req/ack handshake on one side,
// head instruction plus redirect inputs toward the controller on the other.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus8;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus8,
           cond, op, funct, rd,
    input  imem_ack, imem_rdata, stall, pc_src, branch_target
  );

  // Memory/controller side.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus8,
           cond, op, funct, rd,
    output imem_ack, imem_rdata, stall, pc_src, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word fetches over req/ack, buffers the
// returned words with their addresses in a small FIFO, presents the head with
// decoded field slices, and flushes/refetches on a taken-branch redirect.
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic    clk,
  input logic    reset,
  fetch_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  // Branch targets are word addresses; the two low bits carry no meaning.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  state_t        state;
  logic [31:0]   fetch_pc;
  logic          fetch_req;
  logic [31:0]   fetch_addr;

  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          head_valid;
  logic          pop;
  logic          redir;
  logic          push;
  logic [31:0]   target;
  logic [CW-1:0] occ;
  logic          free_slot;
  logic          room_after_push;
  logic [31:0]   head_instr;
  logic [31:0]   head_pc;

  // Handshake and occupancy terms shared by the FSM and the FIFO.
  always_comb begin
    head_valid      = (count != '0);
    pop             = head_valid & ~bus.stall;
    redir           = bus.pc_src & pop;
    target          = align_word(bus.branch_target);
    occ             = count - CW'(pop);
    free_slot       = (occ < DEPTH_C);
    room_after_push = (occ < DEPTH_M1);
    // A redirect on the acking edge wins over the push: the word is stale.
    push            = (state == REQ) & bus.imem_ack & ~redir;
  end

  // Fetch FSM: owns fetch_pc and the registered memory request/address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      fetch_req  <= 1'b0;
      fetch_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redir) fetch_pc <= target;
          fetch_addr <= redir ? target : fetch_pc;
          // After a flush the FIFO is empty, so a slot is always free.
          if (redir || free_slot) begin
            state     <= REQ;
            fetch_req <= 1'b1;
          end else begin
            fetch_req <= 1'b0;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            if (redir) begin
              fetch_pc   <= target;
              fetch_addr <= target;
            end else begin
              fetch_pc   <= fetch_pc + 32'd4;
              fetch_addr <= fetch_pc + 32'd4;
              if (!room_after_push) begin
                state     <= IDLE;
                fetch_req <= 1'b0;
              end
            end
          end else if (redir) begin
            // The pending transfer must still complete; keep its address up
            // and throw its data away when it arrives.
            fetch_pc <= target;
            state    <= DROP;
          end
        end
        DROP: begin
          if (redir) fetch_pc <= target;
          if (bus.imem_ack) begin
            state      <= REQ;
            fetch_addr <= redir ? target : fetch_pc;
          end
        end
        default: begin
          state     <= IDLE;
          fetch_req <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage: data only, so no reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]    <= fetch_pc;
    end
  end

  // FIFO control: pointers and occupancy; a flush overrides push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redir) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head presentation: zeroed when empty so outputs are defined after reset.
  always_comb begin
    head_instr = '0;
    head_pc    = '0;
    if (head_valid) begin
      head_instr = fifo_instr[rd_ptr];
      head_pc    = fifo_pc[rd_ptr];
    end
  end

  assign bus.imem_req    = fetch_req;
  assign bus.imem_addr   = fetch_addr;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_instr;
  assign bus.instr_pc    = head_pc;
  assign bus.pc_plus8    = head_pc + 32'd8;
  assign bus.cond        = head_instr[31:28];
  assign bus.op          = head_instr[27:26];
  assign bus.funct       = head_instr[25:20];
  assign bus.rd          = head_instr[15:12];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table covering streaming,
// stall backpressure, redirects (pending, with ack, while stalled) and address
// wrap, plus hand-written reset sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        pc_src;
  logic        ack_en;
  logic [31:0] target;

  int n_cmp = 0;
  int n_err = 0;

  fetch_if bus ();

  assign bus.stall         = stall;
  assign bus.pc_src        = pc_src;
  assign bus.branch_target = target;
  assign bus.imem_ack      = ack_en & bus.imem_req;
  assign bus.imem_rdata    = bus.imem_addr ^ 32'hA5A5_0000;

  fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        pc_src;
    logic        ack_en;
    logic [31:0] target;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic p, input logic a,
                              input logic [31:0] t, input logic r,
                              input logic [31:0] ad, input logic v,
                              input logic [31:0] pc);
    vec_t x;
    x.stall = s; x.pc_src = p; x.ack_en = a; x.target = t;
    x.exp_req = r; x.exp_addr = ad; x.exp_valid = v; x.exp_pc = pc;
    return x;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Head word, its PC and the field slices, derived from the expected PC.
  task automatic check_head(input string pfx, input logic v,
                            input logic [31:0] pc);
    logic [31:0] ei;
    ei = v ? (pc ^ 32'hA5A5_0000) : 32'h0;
    check({pfx, ".valid"}, {31'b0, bus.instr_valid}, {31'b0, v});
    check({pfx, ".instr_pc"}, bus.instr_pc, v ? pc : 32'h0);
    check({pfx, ".instr"}, bus.instr, ei);
    check({pfx, ".pc_plus8"}, bus.pc_plus8, (v ? pc : 32'h0) + 32'd8);
    check({pfx, ".cond"}, {28'b0, bus.cond}, {28'b0, ei[31:28]});
    check({pfx, ".op"}, {30'b0, bus.op}, {30'b0, ei[27:26]});
    check({pfx, ".funct"}, {26'b0, bus.funct}, {26'b0, ei[25:20]});
    check({pfx, ".rd"}, {28'b0, bus.rd}, {28'b0, ei[15:12]});
  endtask

  initial begin
    reset  = 1'b1;
    stall  = 1'b0;
    pc_src = 1'b0;
    ack_en = 1'b1;
    target = 32'h0;

    // Row k: inputs present before edge k, outputs expected just after it.
    vecs.push_back(mk(0,0,1,0,           1,32'h0,       0,32'h0));
    vecs.push_back(mk(0,0,1,0,           1,32'h4,       1,32'h0));
    vecs.push_back(mk(0,0,1,0,           1,32'h8,       1,32'h4));
    vecs.push_back(mk(0,0,1,0,           1,32'hC,       1,32'h8));
    vecs.push_back(mk(0,0,1,0,           1,32'h10,      1,32'hC));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1,0,1,0,         0,32'h0,       1,32'hC));
    vecs.push_back(mk(0,0,1,0,           1,32'h14,      1,32'h10));
    vecs.push_back(mk(0,0,1,0,           1,32'h18,      1,32'h14));
    vecs.push_back(mk(0,0,1,0,           1,32'h1C,      1,32'h18));
    vecs.push_back(mk(0,1,0,32'h103,     1,32'h1C,      0,32'h0));
    vecs.push_back(mk(0,0,0,0,           1,32'h1C,      0,32'h0));
    vecs.push_back(mk(0,0,0,0,           1,32'h1C,      0,32'h0));
    vecs.push_back(mk(0,0,1,0,           1,32'h100,     0,32'h0));
    vecs.push_back(mk(0,0,1,0,           1,32'h104,     1,32'h100));
    vecs.push_back(mk(0,0,1,0,           1,32'h108,     1,32'h104));
    vecs.push_back(mk(1,1,1,32'h200,     0,32'h0,       1,32'h104));
    vecs.push_back(mk(1,1,1,32'h200,     0,32'h0,       1,32'h104));
    vecs.push_back(mk(0,0,1,0,           1,32'h10C,     1,32'h108));
    vecs.push_back(mk(0,0,1,0,           1,32'h110,     1,32'h10C));
    vecs.push_back(mk(0,1,1,32'h300,     1,32'h300,     0,32'h0));
    vecs.push_back(mk(0,0,1,0,           1,32'h304,     1,32'h300));
    vecs.push_back(mk(0,0,1,0,           1,32'h308,     1,32'h304));
    vecs.push_back(mk(0,1,1,32'hFFFF_FFF8,1,32'hFFFF_FFF8,0,32'h0));
    vecs.push_back(mk(0,0,1,0,           1,32'hFFFF_FFFC,1,32'hFFFF_FFF8));
    vecs.push_back(mk(0,0,1,0,           1,32'h0,       1,32'hFFFF_FFFC));
    vecs.push_back(mk(0,0,1,0,           1,32'h4,       1,32'h0));

    // Reset state while reset is held.
    #3;
    check("rst.req", {31'b0, bus.imem_req}, 32'h0);
    check("rst.addr", bus.imem_addr, 32'h0);
    check_head("rst", 1'b0, 32'h0);

    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    foreach (vecs[i]) begin
      stall  = vecs[i].stall;
      pc_src = vecs[i].pc_src;
      ack_en = vecs[i].ack_en;
      target = vecs[i].target;
      @(posedge clk);
      #1;
      check($sformatf("r%0d.req", i + 1), {31'b0, bus.imem_req},
            {31'b0, vecs[i].exp_req});
      if (vecs[i].exp_req)
        check($sformatf("r%0d.addr", i + 1), bus.imem_addr, vecs[i].exp_addr);
      check_head($sformatf("r%0d", i + 1), vecs[i].exp_valid, vecs[i].exp_pc);
    end

    // Explicit wrap value of the architectural PC read for the last word.
    check("wrap.ffc_plus8", 32'hFFFF_FFFC + 32'd8, bus.pc_plus8 + 32'hFFFF_FFFC);

    // Reset in the middle of a request: outputs drop without a clock edge.
    stall  = 1'b0;
    pc_src = 1'b0;
    ack_en = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("midrst.req", {31'b0, bus.imem_req}, 32'h0);
    check("midrst.addr", bus.imem_addr, 32'h0);
    check_head("midrst", 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check("midrst_hold.req", {31'b0, bus.imem_req}, 32'h0);
    check("midrst_hold.valid", {31'b0, bus.instr_valid}, 32'h0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("restart.req", {31'b0, bus.imem_req}, 32'h1);
    check("restart.addr", bus.imem_addr, 32'h0);
    check_head("restart", 1'b0, 32'h0);
    @(posedge clk);
    #1;
    check("restart2.addr", bus.imem_addr, 32'h4);
    check_head("restart2", 1'b1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the ARM core. It issues word fetches to instruction memory over a req/ack handshake and buffers returned words in a small FIFO. It presents the head instruction, with its decoded field slices, to the controller and consumes the controller's `pc_src` redirect to flush and refetch from the branch target. It sits between instruction memory and the Controller/Datapath pair, on the producing side of the controller's instruction-field and `pc_src` interface.

## Interface
- `DEPTH`, 2: FIFO entries; must be a power of two and at least 2.
- `RESET_PC`, 32'h0000_0000: fetch address after reset; word aligned.

- `clk`: in, 1 bit. The block's single clock.
- `reset`: in, 1 bit. Asynchronous, active-high.
- `imem_req`: out, 1 bit. Fetch request, registered.
- `imem_addr`: out, 32 bits. Fetch address, registered, held stable while `imem_req` is high.
- `imem_ack`: in, 1 bit. Transfer completes at a rising edge where `imem_req` and `imem_ack` are both 1.
- `imem_rdata`: in, 32 bits. Instruction word, valid when `imem_ack`=1.
- `stall`: in, 1 bit. Downstream cannot take the head instruction this cycle.
- `pc_src`: in, 1 bit. Taken-branch redirect from the controller.
- `branch_target`: in, 32 bits. Redirect address; bits [1:0] are ignored and treated as 0.
- `instr_valid`: out, 1 bit. FIFO head is valid.
- `instr`: out, 32 bits. Head instruction word.
- `instr_pc`: out, 32 bits. Address of the head instruction.
- `pc_plus8`: out, 32 bits. `instr_pc` + 8, the architectural PC read value.
- `cond`: out, 4 bits. `instr[31:28]`.
- `op`: out, 2 bits. `instr[27:26]`.
- `funct`: out, 6 bits. `instr[25:20]`.
- `rd`: out, 4 bits. `instr[15:12]`.

## Operation
- Pop: `pop = instr_valid & ~stall`. The head leaves the FIFO at that edge.
- Redirect: `redir = pc_src & pop`. `pc_src` is ignored when `pop` = 0.
- Occupancy after pop: `occ = count - pop`. A free slot exists when `occ < DEPTH`.
- FSM states:
  - **IDLE**: `imem_req`=0.
  - **REQ**: `imem_req`=1, `imem_addr`=`fetch_pc`.
  - **DROP**: `imem_req`=1, `imem_addr` holds the abandoned address.
- IDLE transitions:
  - If `redir`: `fetch_pc` ← target, FIFO flushed.
  - Then go to REQ if a free slot exists (using the post-flush count), else stay in IDLE.
- REQ transitions:
  - ack & ~redir: push {`imem_rdata`, `fetch_pc`}, `fetch_pc` += 4. Go to REQ if `occ + 1 < DEPTH`, else IDLE.
  - ack & redir: data discarded, FIFO flushed, `fetch_pc` ← target, go to REQ.
  - ~ack & redir: FIFO flushed, `fetch_pc` ← target, go to DROP. `imem_addr` stays on the old address.
  - ~ack & ~redir: stay in REQ.
- DROP transitions:
  - ack: data discarded, go to REQ with `imem_addr` = `fetch_pc`.
  - ~ack: stay in DROP.
  - `redir` while in DROP: only updates `fetch_pc`.
- The flush clears `count` and pointers. A push and a flush in the same cycle resolve as a flush.
- The FIFO is never pushed when full; this is guaranteed by the free-slot check.
- Push and pop in the same cycle leave `count` unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- `fetch_pc` increments modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0.
- Field outputs are combinational slices of `instr`. `pc_plus8` is a combinational 32-bit add that wraps.

## Timing
- Reset (async, immediate):
  - State IDLE, `fetch_pc`=`RESET_PC`, `count`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0.
  - `instr`, `instr_pc`=0, so `pc_plus8`=8 and all field outputs are 0.
- `imem_req` first rises at the first rising edge after reset deasserts.
- Fetch latency: ack at edge k with FIFO empty gives `instr_valid`=1 from edge k onward, with no extra cycle.
- Back-to-back: with a memory that always acks, `imem_req` stays high and one word is pushed per cycle while space exists.
- A redirect at edge k puts `imem_addr`=target from edge k if no request was pending. `instr_valid` is 0 from edge k until the target word is acked.
- `imem_req` never drops while a transfer is pending (REQ or DROP without ack).
- Reset mid-transfer abandons the transfer. Memory must tolerate a dropped request.

## Test plan
- Reset release, memory acks every cycle returning `addr`^32'hA5A5_0000: `imem_addr` sequence 0, 4, 8, …; `instr_pc`/`instr` match; `pc_plus8` = `instr_pc`+8; `instr_valid` is 1 from the second cycle.
- `stall`=1 for 6 cycles: `count` reaches DEPTH=2, `imem_req` drops to 0. On stall release the FIFO drains in order 0, 4, then fetching resumes at 8.
- `pc_src`=1 with `pop` at `instr_pc`=8, `branch_target`=32'h103, ack held 0 for 3 cycles: FSM goes to DROP with `imem_addr`=old address. On ack the word is discarded, then a request to 32'h100 follows, and the first valid `instr_pc`=32'h100.
- `pc_src`=1 while `stall`=1: ignored, no flush; the FIFO contents are unchanged.
- Redirect coinciding with an ack in REQ: the acked word is never presented; the next `imem_addr` equals the target.
- `fetch_pc` starting at 32'hFFFF_FFF8: fetches 32'hFFFF_FFF8, 32'hFFFF_FFFC, then 32'h0; `pc_plus8` for 32'hFFFF_FFFC is 32'h4. Also assert `reset` mid-REQ: `imem_req` and `instr_valid` drop immediately, and the restart is at `RESET_PC`.
